// File: rtl/axis_conv_input_skid_if.sv
// rtl/axis_conv_input_skid_if.sv - conv input beat stream: pixels_1/pixels_2/weights/tuser/tlast with valid/ready
interface axis_conv_input_skid_if #(
   parameter int UNITS               = 8,
   parameter int CORES               = 4,
   parameter int WORD_WIDTH          = 8,
   parameter int KERNEL_W_MAX        = 3,
   parameter int TUSER_WIDTH_CONV_IN = 4
);
   logic                                      tvalid;
   logic                                      tready;
   logic                                      tlast;
   logic [TUSER_WIDTH_CONV_IN-1:0]            tuser;
   logic [WORD_WIDTH*UNITS-1:0]               pixels_1_tdata;
   logic [WORD_WIDTH*UNITS-1:0]               pixels_2_tdata;
   logic [WORD_WIDTH*CORES*KERNEL_W_MAX-1:0]  weights_tdata;

   modport master (
      output tvalid, tlast, tuser, pixels_1_tdata, pixels_2_tdata, weights_tdata,
      input  tready
   );

   modport slave (
      input  tvalid, tlast, tuser, pixels_1_tdata, pixels_2_tdata, weights_tdata,
      output tready
   );
endinterface

// File: rtl/axis_conv_input_skid.sv
// rtl/axis_conv_input_skid.sv - registered 2-entry skid buffer in front of the conv engine
// Optional config-run check and packet statistics enabled by macro CONV_SKID_STATS_EN.
module axis_conv_input_skid #(
   parameter int UNITS               = 8,
   parameter int CORES               = 4,
   parameter int WORD_WIDTH          = 8,
   parameter int KERNEL_W_MAX        = 3,
   parameter int BEATS_CONFIG_3X3_1  = 21,
   parameter int BEATS_CONFIG_1X1_1  = 13,
   parameter int TUSER_WIDTH_CONV_IN = 4,
   parameter int I_IS_1X1            = 0,
   parameter int I_IS_CONFIG         = 1
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   axis_conv_input_skid_if.slave         s_axis,
   axis_conv_input_skid_if.master        m_axis,
   output logic                          config_err,
   output logic [15:0]                   packet_count,
   output logic [15:0]                   last_packet_beats
);
   localparam int PW = 1 + TUSER_WIDTH_CONV_IN + 2*WORD_WIDTH*UNITS + WORD_WIDTH*CORES*KERNEL_W_MAX;
   localparam logic [15:0] CFG_3X3 = 16'(BEATS_CONFIG_3X3_1 + 1);
   localparam logic [15:0] CFG_1X1 = 16'(BEATS_CONFIG_1X1_1 + 1);

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [PW-1:0]   r_main;
   logic [PW-1:0]   r_skid;
   logic [PW-1:0]   w_in;
   logic            r_s_tready;
   logic            w_accept;
   logic            w_emit;
   logic            w_load_main_in;
   logic            w_load_main_skid;
   logic            w_load_skid;

   assign w_in = {s_axis.tlast, s_axis.tuser, s_axis.pixels_1_tdata,
                  s_axis.pixels_2_tdata, s_axis.weights_tdata};
   assign w_accept = s_axis.tvalid & r_s_tready;
   assign w_emit   = (r_state != ST_EMPTY) & m_axis.tready;

   always_comb begin
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_nxt    = ST_ONE;
               w_load_main_in = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_accept && w_emit) begin
               w_load_main_in = 1'b1;
            end else if (w_accept) begin
               w_state_nxt = ST_FULL;
               w_load_skid = 1'b1;
            end else if (w_emit) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // s_tready is low here, so only the drain of SKID into MAIN can happen
            if (w_emit) begin
               w_state_nxt      = ST_ONE;
               w_load_main_skid = 1'b1;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state    <= ST_EMPTY;
         r_s_tready <= 1'b0;
         r_main     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_s_tready <= (w_state_nxt != ST_FULL);
         if (w_load_main_in) begin
            r_main <= w_in;
         end else if (w_load_main_skid) begin
            r_main <= r_skid;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (w_load_skid) begin
         r_skid <= w_in;
      end
   end

   assign s_axis.tready = r_s_tready;
   assign m_axis.tvalid = (r_state != ST_EMPTY);
   assign {m_axis.tlast, m_axis.tuser, m_axis.pixels_1_tdata,
           m_axis.pixels_2_tdata, m_axis.weights_tdata} = r_main;

`ifdef CONV_SKID_STATS_EN
   logic        r_cfg_err;
   logic        r_in_cfg;
   logic [15:0] r_cfg_cnt;
   logic [15:0] r_cfg_exp;
   logic [15:0] r_beat_cnt;
   logic [15:0] r_pkt_cnt;
   logic [15:0] r_last_beats;
   logic        w_is_cfg;
   logic        w_is_1x1;

   assign w_is_cfg = s_axis.tuser[I_IS_CONFIG];
   assign w_is_1x1 = s_axis.tuser[I_IS_1X1];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_cfg_err    <= 1'b0;
         r_in_cfg     <= 1'b0;
         r_cfg_cnt    <= '0;
         r_cfg_exp    <= '0;
         r_beat_cnt   <= '0;
         r_pkt_cnt    <= '0;
         r_last_beats <= '0;
      end else if (w_accept) begin
         // Kernel size is taken from the first beat of a config run only
         if (w_is_cfg) begin
            if (!r_in_cfg) begin
               r_cfg_cnt <= 16'd1;
               r_cfg_exp <= w_is_1x1 ? CFG_1X1 : CFG_3X3;
            end else if (r_cfg_cnt != 16'hFFFF) begin
               r_cfg_cnt <= r_cfg_cnt + 16'd1;
            end
            r_in_cfg <= 1'b1;
            if (s_axis.tlast) begin
               r_cfg_err <= 1'b1;
            end
         end else begin
            if (r_in_cfg && (r_cfg_cnt != r_cfg_exp)) begin
               r_cfg_err <= 1'b1;
            end
            r_in_cfg <= 1'b0;
         end
         if (s_axis.tlast) begin
            r_last_beats <= (r_beat_cnt == 16'hFFFF) ? 16'hFFFF : r_beat_cnt + 16'd1;
            r_pkt_cnt    <= r_pkt_cnt + 16'd1;
            r_beat_cnt   <= '0;
         end else if (r_beat_cnt != 16'hFFFF) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
         end
      end
   end

   assign config_err        = r_cfg_err;
   assign packet_count      = r_pkt_cnt;
   assign last_packet_beats = r_last_beats;
`else
   logic w_stats_unused;
   assign w_stats_unused    = &{1'b0, CFG_3X3, CFG_1X1,
                                s_axis.tuser[I_IS_CONFIG], s_axis.tuser[I_IS_1X1]};
   assign config_err        = 1'b0;
   assign packet_count      = 16'd0;
   assign last_packet_beats = 16'd0;
`endif
endmodule

// File: tb/tb_axis_conv_input_skid.sv
// tb/tb_axis_conv_input_skid.sv - scoreboard bench for axis_conv_input_skid
module tb_axis_conv_input_skid;
   localparam int U     = 8;
   localparam int C     = 4;
   localparam int WW    = 8;
   localparam int K     = 3;
   localparam int TW    = 4;
   localparam int I_1X1 = 0;
   localparam int I_CFG = 1;
   localparam int B3X3  = 21;
   localparam int B1X1  = 13;
   localparam int PXW   = WW*U;
   localparam int WTW   = WW*C*K;
   localparam int PW    = 1 + TW + 2*PXW + WTW;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        config_err;
   logic [15:0] packet_count;
   logic [15:0] last_packet_beats;

   always #5 aclk = ~aclk;

   axis_conv_input_skid_if #(.UNITS(U), .CORES(C), .WORD_WIDTH(WW), .KERNEL_W_MAX(K),
                             .TUSER_WIDTH_CONV_IN(TW)) s_if ();
   axis_conv_input_skid_if #(.UNITS(U), .CORES(C), .WORD_WIDTH(WW), .KERNEL_W_MAX(K),
                             .TUSER_WIDTH_CONV_IN(TW)) m_if ();

   axis_conv_input_skid #(
      .UNITS(U), .CORES(C), .WORD_WIDTH(WW), .KERNEL_W_MAX(K),
      .BEATS_CONFIG_3X3_1(B3X3), .BEATS_CONFIG_1X1_1(B1X1),
      .TUSER_WIDTH_CONV_IN(TW), .I_IS_1X1(I_1X1), .I_IS_CONFIG(I_CFG)
   ) dut (
      .aclk              (aclk),
      .aresetn           (aresetn),
      .s_axis            (s_if),
      .m_axis            (m_if),
      .config_err        (config_err),
      .packet_count      (packet_count),
      .last_packet_beats (last_packet_beats)
   );

   int             n_tests = 0;
   int             n_fail  = 0;
   int             n_emit  = 0;
   int             occ;
   bit             mon_en  = 1'b0;
   logic [PW-1:0]  sb_q[$];
   bit             h_cfg[$];
   bit             h_1x1[$];
   bit             h_last[$];

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] m_payload();
      return {m_if.tlast, m_if.tuser, m_if.pixels_1_tdata, m_if.pixels_2_tdata, m_if.weights_tdata};
   endfunction

   function automatic logic [PW-1:0] mk(input bit last, input logic [TW-1:0] user, input int d);
      logic [PXW-1:0] p;
      logic [WTW-1:0] w;
      p = PXW'(d);
      w = WTW'(d);
      return {last, user, p, ~p, w};
   endfunction

   function automatic logic [PW-1:0] rnd_pl(input bit last, input bit cfg);
      logic [PW-1:0] v;
      for (int i = 0; i < PW; i++) v[i] = 1'($urandom);
      v[PW-1] = last;
      v[PW-1-TW+I_CFG] = cfg;
      return v;
   endfunction

   // Output monitor: the queue length is the number of beats the buffer must be holding
   always @(posedge aclk) begin
      #2;
      if (mon_en) begin
         occ = sb_q.size();
         chk("m_tvalid_vs_held", PW'(m_if.tvalid), PW'(occ > 0));
         chk("s_tready_vs_held", PW'(s_if.tready), PW'(occ < 2));
         if (m_if.tvalid && occ > 0) begin
            chk("m_payload", m_payload(), sb_q[0]);
            if (m_if.tready) begin
               void'(sb_q.pop_front());
               n_emit++;
            end
         end
      end
   end

   task automatic step(input bit sv, input logic [PW-1:0] pl, input bit mr, output bit acc);
      @(posedge aclk);
      #1 m_if.tready = mr;
      @(negedge aclk);
      s_if.tvalid = sv;
      {s_if.tlast, s_if.tuser, s_if.pixels_1_tdata, s_if.pixels_2_tdata, s_if.weights_tdata} = pl;
      acc = sv && s_if.tready;
      if (acc) begin
         sb_q.push_back(pl);
         h_last.push_back(pl[PW-1]);
         h_cfg.push_back(pl[PW-1-TW+I_CFG]);
         h_1x1.push_back(pl[PW-1-TW+I_1X1]);
      end
   endtask

   task automatic drain();
      bit a;
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) step(1'b0, '0, 1'b1, a);
      step(1'b0, '0, 1'b1, a);
      chk("drain_empty", PW'(sb_q.size()), '0);
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      aresetn = 1'b0;
      s_if.tvalid = 1'b0;
      sb_q.delete();
      h_cfg.delete();
      h_1x1.delete();
      h_last.delete();
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic check_stats(input string nm);
`ifdef CONV_SKID_STATS_EN
      bit          e_err;
      logic [15:0] e_pk;
      logic [15:0] e_lb;
      int          cur;
      int          run;
      int          need;
      e_err = 0; e_pk = 0; e_lb = 0; cur = 0; run = 0; need = 0;
      for (int i = 0; i < h_cfg.size(); i++) begin
         if (h_cfg[i]) begin
            if (run == 0) need = h_1x1[i] ? B1X1 + 1 : B3X3 + 1;
            run++;
            if (h_last[i]) e_err = 1;
         end else begin
            if (run != 0 && run != need) e_err = 1;
            run = 0;
         end
         if (h_last[i]) begin
            e_lb = (cur + 1 > 65535) ? 16'hFFFF : 16'(cur + 1);
            e_pk = e_pk + 16'd1;
            cur = 0;
         end else if (cur < 65535) begin
            cur++;
         end
      end
      chk({nm, "_config_err"}, PW'(config_err), PW'(e_err));
      chk({nm, "_packet_count"}, PW'(packet_count), PW'(e_pk));
      chk({nm, "_last_packet_beats"}, PW'(last_packet_beats), PW'(e_lb));
`else
      chk({nm, "_config_err_off"}, PW'(config_err), '0);
      chk({nm, "_packet_count_off"}, PW'(packet_count), '0);
      chk({nm, "_last_beats_off"}, PW'(last_packet_beats), '0);
`endif
   endtask

   task automatic send_cfg_run(input int n, input bit is1x1);
      bit a;
      logic [TW-1:0] u;
      int i;
      u = '0;
      u[I_CFG] = 1'b1;
      u[I_1X1] = is1x1;
      i = 0;
      for (int c = 0; c < 200 && i < n; c++) begin
         step(1'b1, mk(1'b0, u, i), 1'b1, a);
         if (a) i++;
      end
      step(1'b0, '0, 1'b1, a);
   endtask

   task automatic send_data(input int n, input bit last_at_end);
      bit a;
      int i;
      i = 0;
      for (int c = 0; c < 400 && i < n; c++) begin
         step(1'b1, mk(last_at_end && (i == n-1), '0, 100+i), 1'b1, a);
         if (a) i++;
      end
      step(1'b0, '0, 1'b1, a);
   endtask

   initial begin
      bit a;
      bit saw_full;
      int i;
      logic [PW-1:0] pl;

      // Reset behaviour with upstream already offering data
      s_if.tvalid = 1'b1;
      {s_if.tlast, s_if.tuser, s_if.pixels_1_tdata, s_if.pixels_2_tdata, s_if.weights_tdata} = '1;
      m_if.tready = 1'b0;
      repeat (3) @(posedge aclk);
      #2;
      chk("reset_m_tvalid", PW'(m_if.tvalid), '0);
      chk("reset_s_tready", PW'(s_if.tready), '0);
      chk("reset_m_data", m_payload(), '0);
      check_stats("reset");
      @(negedge aclk);
      s_if.tvalid = 1'b0;
      aresetn = 1'b1;
      #1 chk("s_tready_before_edge", PW'(s_if.tready), '0);
      mon_en = 1'b1;
      @(posedge aclk);
      #3 chk("s_tready_after_edge", PW'(s_if.tready), PW'(1));

      // Ten indexed beats at full throughput
      n_emit = 0;
      for (int k = 0; k < 10; k++) step(1'b1, mk(k == 9, '0, k), 1'b1, a);
      step(1'b0, '0, 1'b1, a);
      drain();
      chk("stream10_emits", PW'(n_emit), PW'(10));

      // Engine stalls for 4 cycles from the fourth beat
      n_emit = 0;
      saw_full = 1'b0;
      i = 0;
      for (int c = 0; c < 60 && i < 10; c++) begin
         step(1'b1, mk(1'b0, '0, i), !(c >= 3 && c < 7), a);
         if (a) i++;
         if (!s_if.tready) saw_full = 1'b1;
      end
      step(1'b0, '0, 1'b1, a);
      drain();
      chk("stall_skid_filled", PW'(saw_full), PW'(1));
      chk("stall_emits", PW'(n_emit), PW'(10));

      // Randomised traffic with random back-pressure
      do_reset();
      for (int c = 0; c < 600; c++) begin
         pl = rnd_pl($urandom_range(7, 0) == 0, $urandom_range(3, 0) == 0);
         step($urandom_range(3, 0) != 0, pl, $urandom_range(2, 0) != 0, a);
      end
      step(1'b0, '0, 1'b1, a);
      drain();
      check_stats("random");

      // Config runs: exact 3x3 length, then one short
      do_reset();
      send_cfg_run(B3X3 + 1, 1'b0);
      send_data(1, 1'b0);
      drain();
      check_stats("cfg_ok");
`ifdef CONV_SKID_STATS_EN
      chk("cfg_ok_direct", PW'(config_err), '0);
`endif
      send_cfg_run(B3X3, 1'b0);
      send_data(1, 1'b0);
      drain();
      check_stats("cfg_short");
      send_cfg_run(B1X1 + 1, 1'b1);
      send_data(3, 1'b0);
      drain();
      check_stats("cfg_sticky");
`ifdef CONV_SKID_STATS_EN
      chk("cfg_sticky_direct", PW'(config_err), PW'(1));
`endif

      // One 37-beat packet
      do_reset();
      send_data(37, 1'b1);
      drain();
      check_stats("pkt37");
`ifdef CONV_SKID_STATS_EN
      chk("pkt37_beats", PW'(last_packet_beats), PW'(37));
      chk("pkt37_count", PW'(packet_count), PW'(1));
`endif

      // Asynchronous reset while both entries are occupied
      do_reset();
      for (int k = 0; k < 3; k++) step(1'b1, rnd_pl(1'b0, 1'b0), 1'b0, a);
      @(posedge aclk);
      #3;
      chk("full_before_reset", PW'(sb_q.size()), PW'(2));
      mon_en = 1'b0;
      aresetn = 1'b0;
      s_if.tvalid = 1'b0;
      #1;
      chk("midcycle_reset_m_tvalid", PW'(m_if.tvalid), '0);
      chk("midcycle_reset_s_tready", PW'(s_if.tready), '0);
      sb_q.delete();
      h_cfg.delete();
      h_1x1.delete();
      h_last.delete();
      @(negedge aclk);
      aresetn = 1'b1;
      mon_en = 1'b1;
      n_emit = 0;
      for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b1, a);
      chk("no_stale_emit", PW'(n_emit), '0);
      check_stats("after_full_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
